alu_operand_stage: RTL and testbench

- Pipeline stage directly upstream of the combinational ALU.
- Accepts decoded instructions and register-file read data, and applies writeback forwarding.
- Tracks in-flight destination registers with a scoreboard; stalls on RAW/WAW hazards.
- Presents registered operands and opcode to the ALU through a 2-entry skid buffer with valid/ready handshake.

---
 rtl/alu_operand_stage.sv | 158 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU: scoreboard hazard stalls, writeback forwarding and a 2-entry skid buffer.
// Define OPSTAGE_FWD_EN to forward writeback data at capture; otherwise sources wait for the register file.
module alu_operand_stage #(
    parameter int W   = 8,
    parameter int Ops = 4,
    parameter int RA  = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          InValid,
    output logic          InReady,
    input  logic [Ops-1:0] InOP,
    input  logic [RA-1:0] InRdA,
    input  logic [RA-1:0] InRdB,
    input  logic [W-1:0]  InDataA,
    input  logic [W-1:0]  InDataB,
    input  logic          InUseB,
    input  logic          InImmEn,
    input  logic [W-1:0]  InImm,
    input  logic          InWrEn,
    input  logic [RA-1:0] InWrAddr,
    input  logic          FwdValid,
    input  logic [RA-1:0] FwdAddr,
    input  logic [W-1:0]  FwdData,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [W-1:0]  OutA,
    output logic [W-1:0]  OutB,
    output logic [Ops-1:0] OutOP,
    output logic          OutWrEn,
    output logic [RA-1:0] OutWrAddr
);

    localparam int NREG = 2 ** RA;

    logic [NREG-1:0] pending;

    logic            main_valid;
    logic [W-1:0]    main_a;
    logic [W-1:0]    main_b;
    logic [Ops-1:0]  main_op;
    logic            main_wren;
    logic [RA-1:0]   main_wraddr;

    logic            skid_valid;
    logic [W-1:0]    skid_a;
    logic [W-1:0]    skid_b;
    logic [Ops-1:0]  skid_op;
    logic            skid_wren;
    logic [RA-1:0]   skid_wraddr;

    logic            fwd_a;
    logic            fwd_b;
    logic [W-1:0]    src_a;
    logic [W-1:0]    src_b;
    logic [W-1:0]    cap_a;
    logic [W-1:0]    cap_b;
    logic            hazard;
    logic            accept;
    logic            consume;

`ifdef OPSTAGE_FWD_EN
    always_comb begin
        fwd_a = FwdValid && (FwdAddr == InRdA);
        fwd_b = FwdValid && (FwdAddr == InRdB);
        src_a = fwd_a ? FwdData : InDataA;
        src_b = fwd_b ? FwdData : InDataB;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^FwdData;

    always_comb begin
        fwd_a = 1'b0;
        fwd_b = 1'b0;
        src_a = InDataA;
        src_b = InDataB;
    end
`endif

    always_comb begin
        cap_a  = src_a;
        cap_b  = InImmEn ? InImm : (InUseB ? src_b : '0);
        hazard = (pending[InRdA] && !fwd_a)
              || (InUseB && !InImmEn && pending[InRdB] && !fwd_b)
              || (InWrEn && pending[InWrAddr]);
    end

    // Ready only looks at the skid entry, so it never waits on OutReady.
    assign InReady = !skid_valid && !hazard;
    assign accept  = InValid && InReady;
    assign consume = main_valid && OutReady;

    assign OutValid  = main_valid;
    assign OutA      = main_a;
    assign OutB      = main_b;
    assign OutOP     = main_op;
    assign OutWrEn   = main_wren;
    assign OutWrAddr = main_wraddr;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            main_valid  <= 1'b0;
            main_a      <= '0;
            main_b      <= '0;
            main_op     <= '0;
            main_wren   <= 1'b0;
            main_wraddr <= '0;
            skid_valid  <= 1'b0;
            skid_a      <= '0;
            skid_b      <= '0;
            skid_op     <= '0;
            skid_wren   <= 1'b0;
            skid_wraddr <= '0;
        end else begin
            // A full skid forces InReady low, so accept and skid->main never coincide.
            if (consume && skid_valid) begin
                main_valid  <= 1'b1;
                main_a      <= skid_a;
                main_b      <= skid_b;
                main_op     <= skid_op;
                main_wren   <= skid_wren;
                main_wraddr <= skid_wraddr;
                skid_valid  <= 1'b0;
            end else if (accept && (!main_valid || consume)) begin
                main_valid  <= 1'b1;
                main_a      <= cap_a;
                main_b      <= cap_b;
                main_op     <= InOP;
                main_wren   <= InWrEn;
                main_wraddr <= InWrAddr;
            end else if (accept) begin
                skid_valid  <= 1'b1;
                skid_a      <= cap_a;
                skid_b      <= cap_b;
                skid_op     <= InOP;
                skid_wren   <= InWrEn;
                skid_wraddr <= InWrAddr;
            end else if (consume) begin
                main_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pending <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (accept && InWrEn && (InWrAddr == RA'(i)))
                    pending[i] <= 1'b1;
                else if (FwdValid && (FwdAddr == RA'(i)))
                    pending[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; expectations follow OPSTAGE_FWD_EN when it is defined.
module tb_alu_operand_stage;

    localparam int W   = 8;
    localparam int Ops = 4;
    localparam int RA  = 3;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          InValid;
    logic          InReady;
    logic [Ops-1:0] InOP;
    logic [RA-1:0] InRdA;
    logic [RA-1:0] InRdB;
    logic [W-1:0]  InDataA;
    logic [W-1:0]  InDataB;
    logic          InUseB;
    logic          InImmEn;
    logic [W-1:0]  InImm;
    logic          InWrEn;
    logic [RA-1:0] InWrAddr;
    logic          FwdValid;
    logic [RA-1:0] FwdAddr;
    logic [W-1:0]  FwdData;
    logic          OutValid;
    logic          OutReady;
    logic [W-1:0]  OutA;
    logic [W-1:0]  OutB;
    logic [Ops-1:0] OutOP;
    logic          OutWrEn;
    logic [RA-1:0] OutWrAddr;

    int checks = 0;
    int errors = 0;

    alu_operand_stage #(.W(W), .Ops(Ops), .RA(RA)) dut (
        .Clk(Clk), .Reset(Reset),
        .InValid(InValid), .InReady(InReady), .InOP(InOP),
        .InRdA(InRdA), .InRdB(InRdB), .InDataA(InDataA), .InDataB(InDataB),
        .InUseB(InUseB), .InImmEn(InImmEn), .InImm(InImm),
        .InWrEn(InWrEn), .InWrAddr(InWrAddr),
        .FwdValid(FwdValid), .FwdAddr(FwdAddr), .FwdData(FwdData),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutA(OutA), .OutB(OutB), .OutOP(OutOP),
        .OutWrEn(OutWrEn), .OutWrAddr(OutWrAddr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic offer(input logic [Ops-1:0] op, input logic [RA-1:0] ra, input logic [W-1:0] da,
                         input logic [RA-1:0] rb, input logic [W-1:0] db, input logic useb,
                         input logic wren, input logic [RA-1:0] wa);
        InValid  = 1'b1;
        InOP     = op;
        InRdA    = ra;
        InDataA  = da;
        InRdB    = rb;
        InDataB  = db;
        InUseB   = useb;
        InImmEn  = 1'b0;
        InImm    = '0;
        InWrEn   = wren;
        InWrAddr = wa;
        #1;
    endtask

    initial begin
        Reset = 1'b0; InValid = 1'b0; InOP = '0; InRdA = '0; InRdB = '0;
        InDataA = '0; InDataB = '0; InUseB = 1'b0; InImmEn = 1'b0; InImm = '0;
        InWrEn = 1'b0; InWrAddr = '0; FwdValid = 1'b0; FwdAddr = '0; FwdData = '0;
        OutReady = 1'b1;
        step();
        step();
        check("rst_valid", 32'(OutValid), 0);
        check("rst_a", 32'(OutA), 0);
        check("rst_op", 32'(OutOP), 0);
        check("rst_wren", 32'(OutWrEn), 0);
        Reset = 1'b1;

        // Basic ADD with one-cycle latency
        offer(4'h1, 3'd1, 8'd5, 3'd2, 8'd3, 1'b1, 1'b0, 3'd0);
        check("add_inready", 32'(InReady), 1);
        step();
        InValid = 1'b0;
        check("add_valid", 32'(OutValid), 1);
        check("add_a", 32'(OutA), 5);
        check("add_b", 32'(OutB), 3);
        check("add_op", 32'(OutOP), 1);
        check("add_inready2", 32'(InReady), 1);
        step();
        check("add_drain", 32'(OutValid), 0);

        // Backpressure fills main then skid
        OutReady = 1'b0;
        offer(4'h2, 3'd0, 8'h11, 3'd0, 8'h01, 1'b1, 1'b0, 3'd0);
        check("bp_rdy1", 32'(InReady), 1);
        step();
        offer(4'h3, 3'd0, 8'h22, 3'd0, 8'h02, 1'b1, 1'b0, 3'd0);
        check("bp_rdy2", 32'(InReady), 1);
        step();
        offer(4'h4, 3'd0, 8'h33, 3'd0, 8'h03, 1'b1, 1'b0, 3'd0);
        check("bp_rdy3", 32'(InReady), 0);
        InValid = 1'b0;
        check("bp_hold_a", 32'(OutA), 32'h11);
        step();
        check("bp_stable_a", 32'(OutA), 32'h11);
        check("bp_stable_op", 32'(OutOP), 2);
        OutReady = 1'b1;
        step();
        check("bp_second_v", 32'(OutValid), 1);
        check("bp_second_a", 32'(OutA), 32'h22);
        check("bp_second_op", 32'(OutOP), 3);
        step();
        check("bp_empty", 32'(OutValid), 0);

        // RAW on r4
        offer(4'h5, 3'd0, 8'd7, 3'd0, 8'd0, 1'b0, 1'b1, 3'd4);
        step();
        check("raw_w_a", 32'(OutA), 7);
        check("raw_w_wren", 32'(OutWrEn), 1);
        check("raw_w_addr", 32'(OutWrAddr), 4);
        offer(4'h6, 3'd4, 8'h99, 3'd0, 8'd0, 1'b0, 1'b0, 3'd0);
        check("raw_stall", 32'(InReady), 0);
        step();
        check("raw_stall2", 32'(InReady), 0);
        FwdValid = 1'b1; FwdAddr = 3'd4; FwdData = 8'h2A;
        #1;
`ifdef OPSTAGE_FWD_EN
        check("raw_fwd_rdy", 32'(InReady), 1);
        step();
        FwdValid = 1'b0;
        InValid = 1'b0;
        check("raw_fwd_v", 32'(OutValid), 1);
        check("raw_fwd_a", 32'(OutA), 32'h2A);
`else
        check("raw_nofwd_rdy", 32'(InReady), 0);
        step();
        FwdValid = 1'b0;
        InDataA = 8'h2B;
        #1;
        check("raw_nofwd_rdy2", 32'(InReady), 1);
        step();
        InValid = 1'b0;
        check("raw_nofwd_v", 32'(OutValid), 1);
        check("raw_nofwd_a", 32'(OutA), 32'h2B);
`endif
        step();

        // WAW on r6 ignores forwarding until the bit clears
        offer(4'h7, 3'd0, 8'd1, 3'd0, 8'd0, 1'b0, 1'b1, 3'd6);
        step();
        offer(4'h8, 3'd0, 8'd2, 3'd0, 8'd0, 1'b0, 1'b1, 3'd6);
        check("waw_stall", 32'(InReady), 0);
        step();
        FwdValid = 1'b1; FwdAddr = 3'd6; FwdData = 8'h55;
        #1;
        check("waw_fwd_stall", 32'(InReady), 0);
        step();
        FwdValid = 1'b0;
        #1;
        check("waw_clear", 32'(InReady), 1);
        step();
        InValid = 1'b0;
        check("waw_out_op", 32'(OutOP), 8);
        check("waw_out_a", 32'(OutA), 2);
        step();

        // Immediate substitution
        offer(4'h9, 3'd0, 8'd0, 3'd1, 8'h11, 1'b1, 1'b0, 3'd0);
        InImmEn = 1'b1; InImm = 8'h80;
        #1;
        step();
        InImmEn = 1'b0;
        OutReady = 1'b0;
        check("imm_b", 32'(OutB), 32'h80);
        offer(4'hA, 3'd0, 8'h44, 3'd0, 8'd0, 1'b0, 1'b1, 3'd3);
        step();
        InValid = 1'b0;
        #1;
        check("full_inready", 32'(InReady), 0);

        // Reset with both entries full and r3/r6 pending
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        check("mid_rst_valid", 32'(OutValid), 0);
        check("mid_rst_b", 32'(OutB), 0);
        offer(4'hB, 3'd3, 8'h66, 3'd6, 8'h77, 1'b1, 1'b1, 3'd6);
        check("mid_rst_pending", 32'(InReady), 1);
        OutReady = 1'b1;
        step();
        InValid = 1'b0;
        check("post_rst_op", 32'(OutOP), 32'hB);
        check("post_rst_a", 32'(OutA), 32'h66);
        check("post_rst_b", 32'(OutB), 32'h77);
        step();
        check("post_rst_empty", 32'(OutValid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
